// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: MSB-first bit-serial compare of two WIDTH-bit operands
// with a one-cycle done pulse and held eq/gt/lt result registers.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic Clk_CI,
    input  logic Rst_RI,
    input  logic Start_SI,
    input  logic BitValid_SI,
    input  logic A_DI,
    input  logic B_DI,
    output logic Busy_SO,
    output logic Done_SO,
    output logic Eq_DO,
    output logic Gt_DO,
    output logic Lt_DO
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

    state_t state, state_nxt;
    rel_t rel, rel_nxt, rel_bit;
    logic [CW-1:0] cnt, cnt_nxt;
    logic fin;

    // the first differing bit decides; after that the relation is frozen
    assign rel_bit = (rel != REL_EQ) ? rel :
                     (A_DI && !B_DI) ? REL_GT :
                     (!A_DI && B_DI) ? REL_LT : REL_EQ;

    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        rel_nxt = rel;
        fin = 1'b0;
        if (state == IDLE) begin
            if (Start_SI) begin
                state_nxt = RUN;
                cnt_nxt = '0;
                rel_nxt = REL_EQ;
            end
        end else if (BitValid_SI) begin
            rel_nxt = rel_bit;
            if (cnt == CW'(WIDTH - 1)) begin
                state_nxt = IDLE;
                cnt_nxt = '0;
                fin = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state <= IDLE;
            cnt <= '0;
            rel <= REL_EQ;
            Done_SO <= 1'b0;
            Eq_DO <= 1'b0;
            Gt_DO <= 1'b0;
            Lt_DO <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            rel <= rel_nxt;
            Done_SO <= fin;
            if (fin) begin
                Eq_DO <= (rel_bit == REL_EQ);
                Gt_DO <= (rel_bit == REL_GT);
                Lt_DO <= (rel_bit == REL_LT);
            end
        end
    end

    assign Busy_SO = (state == RUN);
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed vectors checked against an integer-compare
// model every cycle, plus literal expectations at each completion.
module tb_serial_magnitude_comparator;
    localparam int W = 8;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, a = 1'b0, b = 1'b0;
    logic busy, done, eq, gt, lt;
    int checks = 0, failures = 0;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .BitValid_SI(valid),
        .A_DI(a), .B_DI(b), .Busy_SO(busy), .Done_SO(done),
        .Eq_DO(eq), .Gt_DO(gt), .Lt_DO(lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: gather the operands as integers and compare them arithmetically
    bit m_busy = 0, m_done = 0, m_eq = 0, m_gt = 0, m_lt = 0;
    int m_n = 0;
    logic [63:0] m_a = '0, m_b = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_eq = 0; m_gt = 0; m_lt = 0; m_n = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_n = 0; m_a = '0; m_b = '0;
                end
            end else if (valid) begin
                m_a = {m_a[62:0], a};
                m_b = {m_b[62:0], b};
                m_n++;
                if (m_n == W) begin
                    m_busy = 0; m_done = 1;
                    m_eq = (m_a == m_b); m_gt = (m_a > m_b); m_lt = (m_a < m_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", busy, m_busy);
        chk("model_done", done, m_done);
        chk("model_result", {eq, gt, lt}, {m_eq, m_gt, m_lt});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // stall_mask[i]=1 inserts one BitValid-low cycle before bit i; start_bit re-asserts Start with that bit
    task automatic run(input string name, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] stall_mask, input int start_bit,
                       input logic [2:0] prev_res, input logic [2:0] exp_res);
        start = 1; valid = 1; a = 1; b = 0;
        tick;
        start = 0;
        chk({name, "_busy"}, busy, 1);
        for (int i = W - 1; i >= 0; i--) begin
            if (stall_mask[i]) begin
                valid = 0;
                tick;
            end
            valid = 1; a = va[i]; b = vb[i]; start = (i == start_bit);
            if (i == 0) begin
                chk({name, "_early_done"}, done, 0);
                chk({name, "_held"}, {eq, gt, lt}, prev_res);
            end
            tick;
            start = 0;
        end
        valid = 0;
        chk({name, "_done"}, done, 1);
        chk({name, "_idle"}, busy, 0);
        chk({name, "_res"}, {eq, gt, lt}, exp_res);
    endtask

    initial begin
        repeat (2) tick;
        chk("reset_outputs", {busy, done, eq, gt, lt}, 5'b0);
        rst = 0;
        tick;
        chk("idle_after_reset", {busy, done, eq, gt, lt}, 5'b0);
        run("eq_a5", 8'hA5, 8'hA5, 8'h00, -1, 3'b000, 3'b100);
        tick;
        chk("done_one_cycle", done, 0);
        run("msb_gt", 8'h80, 8'h7F, 8'h00, -1, 3'b100, 3'b010);
        run("lsb_lt_stall", 8'h3C, 8'h3D, 8'b0100_1010, -1, 3'b010, 3'b001);
        run("start_in_run", 8'h12, 8'h34, 8'h00, 4, 3'b001, 3'b001);
        run("b2b_first", 8'h5A, 8'h5A, 8'h00, -1, 3'b001, 3'b100);
        run("b2b_second", 8'h01, 8'h02, 8'h00, -1, 3'b100, 3'b001);
        start = 1;
        tick;
        start = 0;
        for (int i = 0; i < 3; i++) begin
            valid = 1; a = 1; b = 1;
            tick;
        end
        valid = 0;
        #2 rst = 1;
        #1 chk("async_reset", {busy, done, eq, gt, lt}, 5'b0);
        tick;
        chk("reset_no_done", {busy, done, eq, gt, lt}, 5'b0);
        rst = 0;
        tick;
        run("post_reset_gt", 8'hFF, 8'hFE, 8'h00, -1, 3'b000, 3'b010);
        repeat (3) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
